// File: rtl/sccb_config_sequencer.sv
// SCCB configuration sequencer: walks a synchronous config ROM and issues one
// SCCB register write per entry. Entry words are {reg_addr, reg_data}.
// An all-ones word ends the table. An all-ones address with non-all-ones data
// is a delay marker of `data` units.
// Optional feature macro: SCCB_CFG_DELAY_EN. When it is defined, delay markers
// wait the requested time. When it is undefined, delay markers are skipped.
module sccb_config_sequencer #(
  parameter int unsigned CLK_FREQ      = 25_000_000,
  parameter int unsigned ROM_AW        = 8,
  parameter int unsigned REG_AW        = 8,
  parameter int unsigned REG_DW        = 8,
  parameter int unsigned ROM_LATENCY   = 2,
  parameter int unsigned DELAY_UNIT_US = 1000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic [ROM_AW-1:0]        rom_addr,
  input  logic [REG_AW+REG_DW-1:0] rom_data,
  input  logic                     sccb_ready,
  output logic                     sccb_start,
  output logic [REG_AW-1:0]        sccb_addr,
  output logic [REG_DW-1:0]        sccb_data,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [ROM_AW:0]          wr_count
);

  localparam int unsigned RomW = REG_AW + REG_DW;

  typedef enum logic [2:0] {
    StIdle, StFetch, StDecode, StSend, StWaitBusy, StWaitIdle, StDone
`ifdef SCCB_CFG_DELAY_EN
    , StDelay
`endif
  } state_e;

  state_e              state_q, state_d;
  logic [ROM_AW-1:0]   addr_q, addr_d;
  logic [2:0]          lat_q, lat_d;
  logic [RomW-1:0]     word_q, word_d;
  logic [REG_AW-1:0]   saddr_q, saddr_d;
  logic [REG_DW-1:0]   sdata_q, sdata_d;
  logic                busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [ROM_AW:0]     cnt_q, cnt_d;
  logic                is_end, is_delay, adv;

`ifdef SCCB_CFG_DELAY_EN
  // One delay unit in clock cycles; clamp so sub-MHz clocks still count.
  localparam int unsigned CycRaw     = CLK_FREQ / 1_000_000 * DELAY_UNIT_US;
  localparam int unsigned CycPerUnit = (CycRaw == 0) ? 1 : CycRaw;
  localparam int unsigned UnitW      = $clog2(CycPerUnit + 1);
  logic [UnitW-1:0]  unit_q, unit_d;
  logic [REG_DW-1:0] units_q, units_d;
`endif

  assign is_end   = &word_q;
  assign is_delay = (&word_q[RomW-1:REG_DW]) && !(&word_q[REG_DW-1:0]);

  assign rom_addr  = addr_q;
  assign sccb_addr = saddr_q;
  assign sccb_data = sdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign wr_count  = cnt_q;

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      lat_q   <= '0;
      word_q  <= '0;
      saddr_q <= '0;
      sdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
`ifdef SCCB_CFG_DELAY_EN
      unit_q  <= '0;
      units_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      lat_q   <= lat_d;
      word_q  <= word_d;
      saddr_q <= saddr_d;
      sdata_q <= sdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
`ifdef SCCB_CFG_DELAY_EN
      unit_q  <= unit_d;
      units_q <= units_d;
`endif
    end
  end

  // Next-state logic; sccb_start is gated by sccb_ready so it never fires while the engine is busy.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    lat_d      = lat_q;
    word_d     = word_q;
    saddr_d    = saddr_q;
    sdata_d    = sdata_q;
    busy_d     = busy_q;
    done_d     = done_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    sccb_start = 1'b0;
    adv        = 1'b0;
`ifdef SCCB_CFG_DELAY_EN
    unit_d     = unit_q;
    units_d    = units_q;
`endif
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StFetch;
          addr_d  = '0;
          lat_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      StFetch: begin
        if (lat_q == 3'(ROM_LATENCY - 1)) begin
          word_d  = rom_data;
          state_d = StDecode;
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end
      StDecode: begin
        if (is_end) begin
          state_d = StDone;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b0;
        end else if (is_delay) begin
`ifdef SCCB_CFG_DELAY_EN
          state_d = StDelay;
          units_d = word_q[REG_DW-1:0];
          unit_d  = '0;
`else
          adv = 1'b1;
`endif
        end else begin
          saddr_d = word_q[RomW-1:REG_DW];
          sdata_d = word_q[REG_DW-1:0];
          state_d = StSend;
        end
      end
      StSend: begin
        if (sccb_ready) begin
          sccb_start = 1'b1;
          cnt_d      = cnt_q + 1'b1;
          state_d    = StWaitBusy;
        end
      end
      StWaitBusy: if (!sccb_ready) state_d = StWaitIdle;
      StWaitIdle: if (sccb_ready) adv = 1'b1;
`ifdef SCCB_CFG_DELAY_EN
      StDelay: begin
        if (units_q == '0) begin
          adv = 1'b1;
        end else if (unit_q == UnitW'(CycPerUnit - 1)) begin
          unit_d  = '0;
          units_d = units_q - 1'b1;
        end else begin
          unit_d = unit_q + 1'b1;
        end
      end
`endif
      default: state_d = StIdle;
    endcase

    // Advance to the next entry, or finish with an error after the last ROM slot.
    if (adv) begin
      if (&addr_q) begin
        state_d = StDone;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        err_d   = 1'b1;
      end else begin
        addr_d  = addr_q + 1'b1;
        lat_d   = '0;
        state_d = StFetch;
      end
    end
  end

endmodule

// File: tb/tb_sccb_config_sequencer.sv
// Bench for sccb_config_sequencer: an 8-bit instance (4-entry ROM, latency 2,
// 1-cycle delay units) and a 16-bit-address instance (latency 1).
module tb_sccb_config_sequencer;

  localparam int ReadyLow = 30;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start8, start16;
  logic [1:0]  rom_addr8, rom_addr16;
  logic [15:0] rom_data8;
  logic [23:0] rom_data16;
  logic        ready8 = 1'b1, ready16 = 1'b1;
  logic        sstart8, sstart16, busy8, busy16, done8, done16, err8, err16;
  logic [7:0]  saddr8, sdata8, sdata16;
  logic [15:0] saddr16;
  logic [2:0]  wrc8, wrc16;

  sccb_config_sequencer #(
    .CLK_FREQ(1_000_000), .ROM_AW(2), .REG_AW(8), .REG_DW(8), .ROM_LATENCY(2), .DELAY_UNIT_US(1)
  ) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .rom_addr(rom_addr8), .rom_data(rom_data8),
    .sccb_ready(ready8), .sccb_start(sstart8), .sccb_addr(saddr8), .sccb_data(sdata8),
    .busy(busy8), .done(done8), .err(err8), .wr_count(wrc8)
  );

  sccb_config_sequencer #(
    .CLK_FREQ(1_000_000), .ROM_AW(2), .REG_AW(16), .REG_DW(8), .ROM_LATENCY(1), .DELAY_UNIT_US(1)
  ) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .rom_addr(rom_addr16), .rom_data(rom_data16),
    .sccb_ready(ready16), .sccb_start(sstart16), .sccb_addr(saddr16), .sccb_data(sdata16),
    .busy(busy16), .done(done16), .err(err16), .wr_count(wrc16)
  );

  // ROM models: latency 2 is one register after the array; latency 1 reads combinationally.
  logic [15:0] mem8 [4];
  logic [23:0] mem16 [4];
  logic [15:0] rom8_q;
  always @(posedge clk) rom8_q <= mem8[rom_addr8];
  assign rom_data8  = rom8_q;
  assign rom_data16 = mem16[rom_addr16];

  // SCCB engine models: ready drops for ReadyLow cycles after each accepted start.
  int rcnt8 = 0, rcnt16 = 0;
  always @(posedge clk) begin
    if (sstart8 && ready8) begin
      ready8 <= 1'b0;
      rcnt8  <= ReadyLow;
    end else if (rcnt8 > 0) begin
      rcnt8 <= rcnt8 - 1;
      if (rcnt8 == 1) ready8 <= 1'b1;
    end
  end
  always @(posedge clk) begin
    if (sstart16 && ready16) begin
      ready16 <= 1'b0;
      rcnt16  <= ReadyLow;
    end else if (rcnt16 > 0) begin
      rcnt16 <= rcnt16 - 1;
      if (rcnt16 == 1) ready16 <= 1'b1;
    end
  end

  int n_vec = 0, n_bad = 0;
  function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endfunction

  typedef struct packed {logic [15:0] a; logic [7:0] d;} wr_t;
  wr_t q8[$], q16[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitors, sampled on the falling edge.
  logic prev8 = 1'b0, prev16 = 1'b0;
  int   last8 = 0, gap8 = 0;
  always @(negedge clk) begin
    wr_t e;
    if (busy8 && done8) check("busy_and_done8", {busy8, done8}, 0);
    if (sstart8) begin
      if (prev8) check("start_back_to_back8", prev8, 0);
      if (!ready8) check("start_while_not_ready8", ready8, 1);
      gap8  <= cyc - last8;
      last8 <= cyc;
      if (q8.size() == 0) check("unexpected_write8", q8.size(), 1);
      else begin
        e = q8.pop_front();
        check("sccb_addr8", {8'h0, saddr8}, e.a);
        check("sccb_data8", sdata8, e.d);
      end
    end
    prev8 <= sstart8;
  end
  always @(negedge clk) begin
    wr_t e;
    if (busy16 && done16) check("busy_and_done16", {busy16, done16}, 0);
    if (sstart16) begin
      if (prev16) check("start_back_to_back16", prev16, 0);
      if (q16.size() == 0) check("unexpected_write16", q16.size(), 1);
      else begin
        e = q16.pop_front();
        check("sccb_addr16", saddr16, e.a);
        check("sccb_data16", sdata16, e.d);
      end
    end
    prev16 <= sstart16;
  end

  typedef struct {
    logic [15:0] w[4];
    int          n;
    logic [7:0]  a[4];
    logic [7:0]  d[4];
    logic        e;
  } vec_t;
  vec_t vecs[6];

  task automatic pulse_start8();
    @(negedge clk) start8 = 1'b1;
    @(negedge clk) start8 = 1'b0;
  endtask

  task automatic wait_done8();
    for (int k = 0; k < 3000; k++) begin
      if (done8) return;
      @(negedge clk);
    end
    check("done_timeout8", done8, 1);
  endtask

  task automatic push8(input int idx);
    for (int j = 0; j < vecs[idx].n; j++) q8.push_back({8'h0, vecs[idx].a[j], vecs[idx].d[j]});
  endtask

  task automatic load8(input int idx);
    for (int j = 0; j < 4; j++) mem8[j] = vecs[idx].w[j];
  endtask

  task automatic check_reset8();
    check("rst_sccb_start", sstart8, 0);
    check("rst_sccb_addr", saddr8, 0);
    check("rst_sccb_data", sdata8, 0);
    check("rst_rom_addr", rom_addr8, 0);
    check("rst_busy", busy8, 0);
    check("rst_done", done8, 0);
    check("rst_err", err8, 0);
    check("rst_wr_count", wrc8, 0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int g[6];

  initial begin
    vecs[0] = '{w: '{16'h1280, 16'h1100, 16'hFFFF, 16'h0000}, n: 2,
                a: '{8'h12, 8'h11, 8'h0, 8'h0}, d: '{8'h80, 8'h00, 8'h0, 8'h0}, e: 1'b0};
    vecs[1] = '{w: '{16'h1280, 16'hFF05, 16'h1100, 16'hFFFF}, n: 2,
                a: '{8'h12, 8'h11, 8'h0, 8'h0}, d: '{8'h80, 8'h00, 8'h0, 8'h0}, e: 1'b0};
    vecs[2] = '{w: '{16'h0A01, 16'h0B02, 16'h0C03, 16'h0D04}, n: 4,
                a: '{8'h0A, 8'h0B, 8'h0C, 8'h0D}, d: '{8'h01, 8'h02, 8'h03, 8'h04}, e: 1'b1};
    vecs[3] = '{w: '{16'hFFFF, 16'h1234, 16'h5678, 16'h9ABC}, n: 0,
                a: '{8'h0, 8'h0, 8'h0, 8'h0}, d: '{8'h0, 8'h0, 8'h0, 8'h0}, e: 1'b0};
    vecs[4] = '{w: '{16'hFF00, 16'h3355, 16'hFFFF, 16'h0000}, n: 1,
                a: '{8'h33, 8'h0, 8'h0, 8'h0}, d: '{8'h55, 8'h0, 8'h0, 8'h0}, e: 1'b0};
    vecs[5] = '{w: '{16'hFF01, 16'hFF02, 16'hFF03, 16'h00FF}, n: 1,
                a: '{8'h00, 8'h0, 8'h0, 8'h0}, d: '{8'hFF, 8'h0, 8'h0, 8'h0}, e: 1'b1};

    start8 = 1'b0;
    start16 = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset8();
    check("rst_busy16", busy16, 0);
    check("rst_done16", done16, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven runs.
    for (int i = 0; i < 6; i++) begin
      load8(i);
      push8(i);
      pulse_start8();
      check("busy_after_start", busy8, 1);
      check("done_after_start", done8, 0);
      wait_done8();
      g[i] = gap8;
      check("run_err", err8, vecs[i].e);
      check("run_wr_count", wrc8, vecs[i].n);
      check("run_busy_at_done", busy8, 0);
      check("run_pending_writes", q8.size(), 0);
      if (vecs[i].n > 0) check("held_sccb_addr", saddr8, vecs[i].a[vecs[i].n-1]);
      repeat (3) @(negedge clk);
    end

    // Extra cycles between the two writes caused by the 5-unit delay marker.
`ifdef SCCB_CFG_DELAY_EN
    check("delay_gap_ge5", (g[1] - g[0] >= 5) ? 1 : 0, 1);
`else
    check("delay_skipped_no_gap", (g[1] - g[0] < 5) ? 1 : 0, 1);
`endif

    // start while busy is ignored; start after done reruns from entry 0.
    load8(0);
    push8(0);
    pulse_start8();
    repeat (40) @(negedge clk);
    pulse_start8();
    check("busy_start_still_busy", busy8, 1);
    wait_done8();
    check("busy_start_wr_count", wrc8, 2);
    check("busy_start_pending", q8.size(), 0);
    push8(0);
    @(negedge clk) start8 = 1'b1;
    @(negedge clk) start8 = 1'b0;
    check("rerun_done_drops", done8, 0);
    check("rerun_busy", busy8, 1);
    check("rerun_rom_addr", rom_addr8, 0);
    check("rerun_wr_count", wrc8, 0);
    wait_done8();
    check("rerun_final_wr_count", wrc8, 2);

    // Reset while waiting for the engine to go idle.
    repeat (3) @(negedge clk);
    q8.push_back({8'h0, 8'h12, 8'h80});
    pulse_start8();
    for (int k = 0; k < 200 && wrc8 != 3'd1; k++) @(negedge clk);
    check("mid_reset_first_write", wrc8, 1);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset8();
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    check("post_reset_wr_count", wrc8, 0);
    check("post_reset_busy", busy8, 0);
    check("post_reset_pending", q8.size(), 0);

    // 16-bit register address, ROM latency 1.
    mem16[0] = 24'h300882;
    mem16[1] = 24'hFFFFFF;
    mem16[2] = 24'h000000;
    mem16[3] = 24'h000000;
    q16.push_back({16'h3008, 8'h82});
    @(negedge clk) start16 = 1'b1;
    @(negedge clk) start16 = 1'b0;
    check("w16_busy", busy16, 1);
    for (int k = 0; k < 500 && !done16; k++) @(negedge clk);
    check("w16_done", done16, 1);
    check("w16_err", err16, 0);
    check("w16_wr_count", wrc16, 1);
    check("w16_pending", q16.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
